// File: rtl/mario_dead_anim.sv
// Dead-Mario animation: freeze, hop up, fall off screen, plus a two-stage
// sprite pipeline (beam position -> ROM address -> registered colour).
//
// state  | meaning
// IDLE   | waiting for a death trigger, sprite hidden
// FREEZE | Mario held in place for FREEZE_FRAMES frame ticks
// RISE   | moving upward, velocity still negative
// FALL   | moving downward until below the visible area
// DONE   | off screen, sprite hidden, waiting for a new trigger
module mario_dead_anim #(
  parameter int          SPR_W         = 21,
  parameter int          FREEZE_FRAMES = 30,
  parameter int          JUMP_V        = 8,
  parameter int          GRAVITY       = 1,
  parameter int          MAX_FALL      = 8,
  parameter int          SCREEN_H      = 480,
  parameter logic [23:0] TRANSP        = 24'h800080
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        dead_trigger,
  input  logic [9:0]  start_x,
  input  logic [9:0]  start_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [23:0] rom_color,
  output logic [8:0]  rom_addr,
  output logic        pixel_on,
  output logic [23:0] pixel_color,
  output logic        active,
  output logic        anim_done
);

  localparam int CNT_W = $clog2(FREEZE_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FREEZE_FRAMES - 1);
  localparam logic signed [5:0]  JUMP_S     = 6'(JUMP_V);
  localparam logic signed [6:0]  GRAV_S     = 7'(GRAVITY);
  localparam logic signed [6:0]  MAX_FALL_S = 7'(MAX_FALL);
  localparam logic signed [10:0] SCREEN_H_S = 11'(SCREEN_H);
  localparam logic signed [10:0] SPR_S      = 11'(SPR_W);

  typedef enum logic [2:0] {IDLE, FREEZE, RISE, FALL, DONE} state_t;

  state_t             state, state_n;
  logic [9:0]         pos_x, pos_x_n;
  logic signed [10:0] pos_y, pos_y_n;
  logic signed [5:0]  vel, vel_n;
  logic [CNT_W-1:0]   freeze_cnt, freeze_cnt_n;
  logic               frame_clk_d;
  logic               frame_tick;
  logic signed [6:0]  vel_inc;
  logic signed [5:0]  vel_sat;
  logic signed [10:0] pos_y_step;
  logic signed [10:0] dx, dy;
  logic               in_win, in_win_d;
  logic [8:0]         addr_c;

  assign frame_tick = frame_clk & ~frame_clk_d;
  assign active     = (state == FREEZE) || (state == RISE) || (state == FALL);
  assign anim_done  = (state == DONE);

  always_comb begin
    state_n      = state;
    pos_x_n      = pos_x;
    pos_y_n      = pos_y;
    vel_n        = vel;
    freeze_cnt_n = freeze_cnt;
    vel_inc      = {vel[5], vel} + GRAV_S;
    vel_sat      = (vel_inc > MAX_FALL_S) ? MAX_FALL_S[5:0] : vel_inc[5:0];
    pos_y_step   = pos_y + {{5{vel[5]}}, vel};
    case (state)
      IDLE, DONE: begin
        // trigger takes priority over a coincident frame tick
        if (dead_trigger) begin
          pos_x_n      = start_x;
          pos_y_n      = {1'b0, start_y};
          freeze_cnt_n = '0;
          state_n      = FREEZE;
        end
      end
      FREEZE: begin
        if (frame_tick) begin
          freeze_cnt_n = freeze_cnt + 1'b1;
          if (freeze_cnt == CNT_LAST) begin
            vel_n   = -JUMP_S;
            state_n = RISE;
          end
        end
      end
      RISE: begin
        if (frame_tick) begin
          pos_y_n = pos_y_step;
          vel_n   = vel_sat;
          if (!vel_sat[5]) state_n = FALL;
        end
      end
      FALL: begin
        if (frame_tick) begin
          pos_y_n = pos_y_step;
          vel_n   = vel_sat;
          if (pos_y_step >= SCREEN_H_S) state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Signed offsets let a sprite partly above the screen top clip cleanly.
  always_comb begin
    dx     = $signed({1'b0, DrawX}) - $signed({1'b0, pos_x});
    dy     = $signed({1'b0, DrawY}) - pos_y;
    in_win = active && (dx >= 0) && (dx < SPR_S) && (dy >= 0) && (dy < SPR_S);
    addr_c = in_win ? (({4'd0, dy[4:0]} * 9'(SPR_W)) + {4'd0, dx[4:0]}) : 9'd0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      pos_x       <= '0;
      pos_y       <= '0;
      vel         <= '0;
      freeze_cnt  <= '0;
      frame_clk_d <= 1'b0;
      rom_addr    <= '0;
      in_win_d    <= 1'b0;
      pixel_on    <= 1'b0;
      pixel_color <= '0;
    end else begin
      state       <= state_n;
      pos_x       <= pos_x_n;
      pos_y       <= pos_y_n;
      vel         <= vel_n;
      freeze_cnt  <= freeze_cnt_n;
      frame_clk_d <= frame_clk;
      rom_addr    <= addr_c;
      in_win_d    <= in_win;
      // active gate keeps a lagging in_win_d from lighting a pixel in DONE
      pixel_on    <= in_win_d && active && (rom_color != TRANSP);
      pixel_color <= (in_win_d && active && (rom_color != TRANSP)) ? rom_color : 24'd0;
    end
  end

endmodule

// File: tb/tb_mario_dead_anim.sv
// Bench for mario_dead_anim: motion model plus a scoreboard of expected
// ROM addresses and pixel outputs matched against the pipelined DUT.
module tb_mario_dead_anim;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, dead_trigger;
  logic [9:0]  start_x, start_y, DrawX, DrawY;
  logic [23:0] rom_color;
  logic [8:0]  rom_addr;
  logic        pixel_on;
  logic [23:0] pixel_color;
  logic        active, anim_done;

  mario_dead_anim dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .dead_trigger(dead_trigger),
    .start_x(start_x), .start_y(start_y), .DrawX(DrawX), .DrawY(DrawY),
    .rom_color(rom_color), .rom_addr(rom_addr), .pixel_on(pixel_on),
    .pixel_color(pixel_color), .active(active), .anim_done(anim_done)
  );

  always #10 Clk = ~Clk;

  // sprite ROM stand-in: colour derived from the address unless forced
  int cmode = 0;
  always_comb begin
    case (cmode)
      1:       rom_color = 24'h800080;
      2:       rom_color = 24'hF83800;
      default: rom_color = {8'hA5, 7'd0, rom_addr};
    endcase
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic [8:0]  addr;
    logic        on;
    logic [23:0] col;
  } exp_t;

  exp_t aq[$];
  exp_t pq[$];

  always @(negedge Clk) begin : mon
    exp_t e;
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      e = aq.pop_front();
      check("rom_addr", 32'(rom_addr), 32'(e.addr));
    end
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      e = pq.pop_front();
      check("pixel_on", 32'(pixel_on), 32'(e.on));
      check("pixel_color", 32'(pixel_color), 32'(e.col));
    end
  end

  // phase: 0 idle, 1 freeze, 2 rise, 3 fall, 4 done
  int ph = 0, ex = 0, ey = 0, ev = 0, ecnt = 0;

  task automatic model_tick();
    case (ph)
      1: begin
        if (ecnt == 29) begin ev = -8; ph = 2; end
        ecnt++;
      end
      2, 3: begin
        ey += ev;
        ev = (ev + 1 > 8) ? 8 : ev + 1;
        if (ph == 2) begin
          if (ev >= 0) ph = 3;
        end else if (ey >= 480) ph = 4;
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(negedge Clk); frame_clk = 1'b1;
    @(negedge Clk); frame_clk = 1'b0;
    model_tick();
    check("active", 32'(active), 32'(ph >= 1 && ph <= 3));
    check("anim_done", 32'(anim_done), 32'(ph == 4));
  endtask

  task automatic trig(input int x, input int y, input bit with_tick);
    @(negedge Clk);
    start_x = 10'(x); start_y = 10'(y);
    dead_trigger = 1'b1; frame_clk = with_tick;
    @(negedge Clk);
    dead_trigger = 1'b0; frame_clk = 1'b0;
    if (ph == 0 || ph == 4) begin ph = 1; ex = x; ey = y; ecnt = 0; end
  endtask

  task automatic push_exp(input logic [8:0] addr, input bit inw);
    exp_t e;
    logic [23:0] col;
    e.due = cyc + 1; e.addr = addr; e.on = 1'b0; e.col = '0;
    aq.push_back(e);
    col = (cmode == 1) ? 24'h800080 : (cmode == 2) ? 24'hF83800 : {8'hA5, 7'd0, addr};
    e.due = cyc + 2;
    e.on  = inw && (col != 24'h800080);
    e.col = e.on ? col : 24'd0;
    pq.push_back(e);
  endtask

  task automatic probe(input int x, input int y);
    int dx, dy;
    bit inw;
    @(negedge Clk); DrawX = 10'(x); DrawY = 10'(y);
    dx = x - ex; dy = y - ey;
    inw = (ph >= 1 && ph <= 3) && dx >= 0 && dx < 21 && dy >= 0 && dy < 21;
    push_exp(inw ? 9'(dy * 21 + dx) : 9'd0, inw);
  endtask

  // expectation taken straight from the hand-worked trajectory
  task automatic probe_fixed(input int x, input int y, input int addr);
    @(negedge Clk); DrawX = 10'(x); DrawY = 10'(y);
    push_exp(9'(addr), 1'b1);
  endtask

  task automatic drain();
    repeat (3) @(negedge Clk);
  endtask

  int seq [8] = '{192, 185, 179, 174, 170, 167, 165, 164};

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; dead_trigger = 1'b0;
    start_x = '0; start_y = '0; DrawX = '0; DrawY = '0;
    repeat (3) @(negedge Clk);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_pixel_on", 32'(pixel_on), 0);
    check("rst_pixel_color", 32'(pixel_color), 0);
    check("rst_active", 32'(active), 0);
    check("rst_anim_done", 32'(anim_done), 0);
    @(negedge Clk); Reset = 1'b0;
    probe(0, 0); drain();

    // freeze at (100,200) and window probes
    trig(100, 200, 1'b0);
    check("trig_active", 32'(active), 1);
    repeat (29) tick();
    probe(100, 200); probe(120, 220); probe(121, 220); probe(110, 210);
    probe(99, 205); probe(105, 221); drain();
    cmode = 1; probe(105, 203); drain();
    cmode = 2; probe(105, 203); probe(130, 203); drain();
    cmode = 0;
    tick();
    probe(101, 200); drain();

    // rise with an ignored trigger part-way through
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) trig(0, 0, 1'b0);
      probe_fixed(101, seq[i], 1); probe(101, ey); drain();
    end
    tick(); probe_fixed(101, 164, 1); drain();
    tick(); probe_fixed(101, 165, 1); drain();
    for (int n = 0; n < 100 && ph != 4; n++) tick();
    check("done_flag", 32'(anim_done), 1);
    check("done_active", 32'(active), 0);
    probe(100, 479); probe(100, 500); drain();

    // restart from DONE with a coincident tick; apex above the screen top
    trig(300, 10, 1'b1);
    repeat (30) tick();
    probe(301, 10); drain();
    tick(); probe(301, 2); drain();
    repeat (7) tick();
    probe(301, 0); probe(300, 0); drain();
    for (int n = 0; n < 20 && ey != -16; n++) tick();
    probe_fixed(301, 0, 337); probe(305, 4); drain();
    for (int n = 0; n < 100 && ph != 4; n++) tick();
    check("done2_flag", 32'(anim_done), 1);
    probe(300, 479); drain();

    // reset in the middle of the rise
    trig(50, 300, 1'b0);
    repeat (33) tick();
    probe(51, ey); drain();
    @(negedge Clk); Reset = 1'b1;
    #1;
    check("mid_rst_rom_addr", 32'(rom_addr), 0);
    check("mid_rst_pixel_on", 32'(pixel_on), 0);
    check("mid_rst_pixel_color", 32'(pixel_color), 0);
    check("mid_rst_active", 32'(active), 0);
    check("mid_rst_anim_done", 32'(anim_done), 0);
    ph = 0; ex = 0; ey = 0; ev = 0; ecnt = 0;
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_pixel_on", 32'(pixel_on), 0);
    probe(51, 279); probe(0, 0); drain();
    tick();

    check("aq_left", 32'(aq.size()), 0);
    check("pq_left", 32'(pq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mario_dead_anim.md
Name: mario_dead_anim

Overview:
- Drives Mario's death animation and feeds the 21x21 dead-Mario sprite ROM, which is 441 entries with a 9-bit address and a combinational 24-bit colour out.
- On a death trigger it freezes Mario in place, then moves him up and back down under gravity until he leaves the screen.
- Each cycle it converts the VGA beam position (DrawX/DrawY) into a ROM read address and registers the returned colour.
- It outputs a pixel-on flag and colour that the colour mapper consumes. Palette key 24'h800080 means transparent.

Parameters:
- SPR_W, 21, sprite width/height in pixels (square sprite).
- FREEZE_FRAMES, 30, frames Mario is held still after trigger.
- JUMP_V, 8, initial upward speed in px/frame.
- GRAVITY, 1, velocity increment per frame.
- MAX_FALL, 8, terminal downward speed in px/frame.
- SCREEN_H, 480, visible height; leaving it ends the animation.
- TRANSP, 24'h800080, colour key treated as transparent.

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  vsync-rate frame strobe; the block detects its rising edge internally
- dead_trigger  in  1  one-cycle pulse that starts the animation
- start_x  in  10  Mario x at death; latched on trigger
- start_y  in  10  Mario y at death; latched on trigger
- DrawX  in  10  current beam x
- DrawY  in  10  current beam y
- rom_color  in  24  colour returned by the sprite ROM (combinational from rom_addr)
- rom_addr  out  9  sprite ROM read address
- pixel_on  out  1  registered flag: current pixel belongs to the sprite and is opaque
- pixel_color  out  24  registered sprite colour
- active  out  1  high in FREEZE, RISE, FALL
- anim_done  out  1  high in DONE

Behaviour:
- Reset values (asynchronous): state=IDLE; pos_x=0; pos_y=0 (11-bit signed); vel=0 (6-bit signed); freeze_cnt=0; rom_addr=0; pixel_on=0; pixel_color=0; frame_clk_d=0.
- frame_tick = frame_clk & ~frame_clk_d. It is a one-Clk pulse, and all motion updates happen only on frame_tick.
- IDLE:
  - dead_trigger latches pos_x=start_x and pos_y=start_y (zero-extended), sets freeze_cnt=0, and moves to FREEZE.
- FREEZE:
  - Each frame_tick increments freeze_cnt.
  - On the tick where freeze_cnt==FREEZE_FRAMES-1: vel=-JUMP_V, move to RISE.
  - Position does not change.
- RISE/FALL, on each frame_tick:
  - pos_y += vel (signed).
  - vel = min(vel+GRAVITY, MAX_FALL).
  - RISE goes to FALL when the updated vel >= 0.
  - In FALL, if the updated pos_y >= SCREEN_H, go to DONE.
  - pos_x never changes.
- DONE:
  - Holds until dead_trigger, which restarts exactly as from IDLE, or until Reset.
- dead_trigger is ignored in FREEZE, RISE and FALL.
- If dead_trigger and frame_tick coincide in IDLE/DONE, the trigger wins and no motion update is applied that cycle.
- Address stage (cycle 1), combinational window test:
  - dx = DrawX - pos_x and dy = DrawY - pos_y, both signed 11-bit.
  - in_win = (0 <= dx < SPR_W) & (0 <= dy < SPR_W) & active.
  - Registered: rom_addr = in_win ? dy*SPR_W + dx : 0; in_win_d = in_win.
  - Negative pos_y (apex above screen top) must clip correctly via the signed compare.
- Colour stage (cycle 2), registered:
  - pixel_on = in_win_d & (rom_color != TRANSP).
  - pixel_color = pixel_on ? rom_color : 0.
- Total latency from DrawX/DrawY to pixel_on/pixel_color is 2 Clk cycles. The downstream stage compensates.
- pixel_on is 0 in IDLE and DONE.
- Reset asserted mid-animation returns everything to reset values immediately. The first output after release is pixel_on=0.
- rom_addr range is 0..440. No address >440 is ever issued.

Test Plan:
- Reset, trigger with start=(100,200), then 29 frame ticks -> state FREEZE, pos_y=200. Tick 30 -> RISE, vel=-8.
- Continue ticking -> pos_y sequence 192,185,179,174,170,167,165,164. After the 8th tick vel=0 and the state is FALL. The apex is 164.
- During FREEZE at (100,200):
  - DrawX=100, DrawY=200 -> rom_addr=0 one cycle later.
  - DrawX=120, DrawY=220 -> rom_addr=440.
  - DrawX=121 -> pixel_on=0 two cycles later.
- In the window, rom_color=24'h800080 -> pixel_on=0. rom_color=24'hF83800 -> pixel_on=1 and pixel_color=F83800, exactly 2 cycles after the DrawX/DrawY change.
- start_y=10: apex pos_y=-26; DrawY=0, DrawX=pos_x -> rom_addr=26*21=546 must NOT occur, and the address is 26*21+0 only if dy<21. So pixel_on=0 at the top rows, and the row dy=26 is invisible. Then fall until pos_y>=480 -> anim_done=1, active=0, pixel_on=0.
- Reset pulsed mid-RISE -> state IDLE, all outputs 0. A dead_trigger during RISE is ignored, and pos_y continues the sequence unchanged.
